// File: rtl/zero_detect_pipe.sv
// zero_detect_pipe: pipelined zero / all-ones / nonzero detector with a
// valid/ready handshake on both sides and a saturating hit counter.
// The OR and AND reductions are built as balanced 2-input trees. Their levels
// are spread evenly over PIPE register stages.
// Optional feature: define ZERO_DETECT_PIPE_STICKY_EN to get a sticky hit
// flag. Without it, sticky is tied to 0 and no register exists for it.
module zero_detect_pipe #(
   parameter int WIDTH = 16,
   parameter int PIPE  = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_flag,
   output logic [7:0]       hit_cnt,
   output logic             sticky,
   input  logic             clr
);

   localparam int LOG_W = $clog2(WIDTH);

   // Number of tree levels completed by the end of stage index s (0..PIPE).
   function automatic int lvl(input int s);
      return (LOG_W * s) / PIPE;
   endfunction

   // Apply tree levels lo..hi-1 to a partial vector. Results for the pairs
   // land in the low bits. Bits above the surviving width are zeroed, so the
   // last stage can be collapsed with a plain OR.
   function automatic logic [WIDTH-1:0] reduce_lv(input logic [WIDTH-1:0] v,
                                                  input int lo, input int hi,
                                                  input logic is_and);
      logic [WIDTH-1:0] r;
      r = v;
      for (int l = 0; l < LOG_W; l++) begin
         if (l >= lo && l < hi) begin
            for (int i = 0; i < WIDTH / 2; i++) begin
               if (i < (WIDTH >> (l + 1)))
                  r[i] = is_and ? (r[2*i] & r[2*i+1]) : (r[2*i] | r[2*i+1]);
            end
         end
      end
      for (int i = 0; i < WIDTH; i++) begin
         if (i >= (WIDTH >> hi)) r[i] = 1'b0;
      end
      return r;
   endfunction

   logic [PIPE-1:0]  valid_q;
   logic [PIPE-1:0]  load;
   logic [PIPE-1:0]  valid_src;
   logic [WIDTH-1:0] or_q    [PIPE];
   logic [WIDTH-1:0] and_q   [PIPE];
   logic [WIDTH-1:0] or_src  [PIPE];
   logic [WIDTH-1:0] and_src [PIPE];
   logic [WIDTH-1:0] or_d    [PIPE];
   logic [WIDTH-1:0] and_d   [PIPE];
   logic [1:0]       mode_q  [PIPE];
   logic [1:0]       mode_src[PIPE];
   logic             flag_raw;
   logic             hit;
   logic [7:0]       hit_cnt_q, hit_cnt_d;

   // Load enables ripple back from the output: a stage loads when empty or when its successor loads.
   always_comb begin
      logic adv;
      adv  = out_ready;
      load = '0;
      for (int k = PIPE - 1; k >= 0; k--) begin
         adv     = ~valid_q[k] | adv;
         load[k] = adv;
      end
   end

   assign in_ready = load[0];

   // Gather each stage's source and apply that stage's share of the tree levels.
   always_comb begin
      or_src[0]    = in_data;
      and_src[0]   = in_data;
      mode_src[0]  = in_mode;
      valid_src    = '0;
      valid_src[0] = in_valid;
      for (int k = 1; k < PIPE; k++) begin
         or_src[k]    = or_q[k-1];
         and_src[k]   = and_q[k-1];
         mode_src[k]  = mode_q[k-1];
         valid_src[k] = valid_q[k-1];
      end
      for (int k = 0; k < PIPE; k++) begin
         or_d[k]  = reduce_lv(or_src[k],  lvl(k), lvl(k + 1), 1'b0);
         and_d[k] = reduce_lv(and_src[k], lvl(k), lvl(k + 1), 1'b1);
      end
   end

   // Stage registers: each stage holds its valid bit, partial reductions and mode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         for (int k = 0; k < PIPE; k++) begin
            or_q[k]   <= '0;
            and_q[k]  <= '0;
            mode_q[k] <= 2'b00;
         end
      end else begin
         for (int k = 0; k < PIPE; k++) begin
            if (load[k]) begin
               valid_q[k] <= valid_src[k];
               or_q[k]    <= or_d[k];
               and_q[k]   <= and_d[k];
               mode_q[k]  <= mode_src[k];
            end
         end
      end
   end

   // Final mode select. The flag is gated by valid, so it reads 0 when the output is empty.
   always_comb begin
      flag_raw = 1'b0;
      case (mode_q[PIPE-1])
         2'b00:   flag_raw = ~(|or_q[PIPE-1]);
         2'b01:   flag_raw = |and_q[PIPE-1];
         2'b10:   flag_raw = |or_q[PIPE-1];
         default: flag_raw = 1'b0;
      endcase
   end

   assign out_valid = valid_q[PIPE-1];
   assign out_flag  = out_valid & flag_raw;
   assign hit       = out_valid & out_ready & out_flag;

   // Saturating hit counter. If clr and a hit arrive together, the count becomes 1.
   always_comb begin
      hit_cnt_d = hit_cnt_q;
      if (clr)
         hit_cnt_d = hit ? 8'd1 : 8'd0;
      else if (hit && hit_cnt_q != 8'hFF)
         hit_cnt_d = hit_cnt_q + 8'd1;
   end

   // Hit counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) hit_cnt_q <= 8'd0;
      else        hit_cnt_q <= hit_cnt_d;
   end

   assign hit_cnt = hit_cnt_q;

`ifdef ZERO_DETECT_PIPE_STICKY_EN
   logic sticky_q;

   // Sticky hit flag. A set takes priority over a simultaneous clr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   sticky_q <= 1'b0;
      else if (hit) sticky_q <= 1'b1;
      else if (clr) sticky_q <= 1'b0;
   end

   assign sticky = sticky_q;
`else
   assign sticky = 1'b0;
`endif

endmodule

// File: tb/tb_zero_detect_pipe.sv
module tb_zero_detect_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = '0;
   logic [1:0]  in_mode = 2'b00;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        out_flag;
   logic [7:0]  hit_cnt;
   logic        sticky;
   logic        clr = 1'b0;

`ifdef ZERO_DETECT_PIPE_STICKY_EN
   localparam logic STK = 1'b1;
`else
   localparam logic STK = 1'b0;
`endif

   zero_detect_pipe #(.WIDTH(16), .PIPE(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_flag  (out_flag),
      .hit_cnt   (hit_cnt),
      .sticky    (sticky),
      .clr       (clr)
   );

   always #5 clk = ~clk;

   int   errors = 0;
   int   checks = 0;
   int   n_out  = 0;
   logic cur_exp = 1'b0;
   logic exp_q[$];
   logic stall_seen = 1'b0;
   logic stall_flag = 1'b0;

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b expected %0b", name, act, exp);
      end
   endtask

   task automatic chkn(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Input side of the scoreboard: queue the hand-computed flag on every accepted input.
   always @(negedge clk) begin
      if (rst_n && in_valid && in_ready) exp_q.push_back(cur_exp);
   end

   always @(negedge rst_n) exp_q.delete();

   // Output monitor: compare each delivered result and check that the output holds while stalled.
   always @(negedge clk) begin
      if (rst_n) begin
         if (stall_seen) begin
            chk1("stall_valid", out_valid, 1'b1);
            chk1("stall_flag", out_flag, stall_flag);
         end
         if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) chk1("unexpected_out", out_valid, 1'b0);
            else                   chk1("out_flag", out_flag, exp_q.pop_front());
         end
         stall_seen = out_valid && !out_ready;
         stall_flag = out_flag;
      end else begin
         stall_seen = 1'b0;
      end
   end

   task automatic send(input logic [15:0] d, input logic [1:0] m, input logic e);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_mode  = m;
      cur_exp  = e;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 200);
      if (!in_ready) chk1("send_timeout", in_ready, 1'b1);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   logic [15:0] bp_data[5];
   logic [1:0]  bp_mode[5];
   logic        bp_exp[5];

   initial begin
      int n0;
      int acc;

      bp_data[0] = 16'h0000; bp_mode[0] = 2'b00; bp_exp[0] = 1'b1;
      bp_data[1] = 16'h00FF; bp_mode[1] = 2'b01; bp_exp[1] = 1'b0;
      bp_data[2] = 16'hFFFF; bp_mode[2] = 2'b01; bp_exp[2] = 1'b1;
      bp_data[3] = 16'h0100; bp_mode[3] = 2'b10; bp_exp[3] = 1'b1;
      bp_data[4] = 16'hFFFF; bp_mode[4] = 2'b00; bp_exp[4] = 1'b0;

      // Reset state
      #3 rst_n = 1'b0;
      #1;
      chk1("rst_out_valid", out_valid, 1'b0);
      chk1("rst_out_flag", out_flag, 1'b0);
      chkn("rst_hit_cnt", int'(hit_cnt), 0);
      chk1("rst_sticky", sticky, 1'b0);
      out_ready = 1'b1;
      #18 rst_n = 1'b1;
      #1;
      chk1("rst_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;

      // Single zero hit: PIPE=2 cycles of latency
      send(16'h0000, 2'b00, 1'b1);
      in_valid = 1'b0;
      @(negedge clk);
      chk1("lat_early", out_valid, 1'b0);
      @(negedge clk);
      chk1("lat_valid", out_valid, 1'b1);
      @(posedge clk);
      #1;
      chkn("hit_cnt_1", int'(hit_cnt), 1);
      chk1("sticky_hit", sticky, STK);

      // Four results back-to-back with no gaps
      n0 = n_out;
      send(16'hFFFF, 2'b01, 1'b1);
      send(16'h8000, 2'b00, 1'b0);
      send(16'h0001, 2'b10, 1'b1);
      send(16'h1234, 2'b11, 1'b0);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      #1;
      chkn("b2b_count", n_out - n0, 4);
      idle(3);
      chkn("hit_cnt_3", int'(hit_cnt), 3);

      // Backpressure: exactly two entries accepted, then in_ready drops
      n0 = n_out;
      out_ready = 1'b0;
      acc = 0;
      in_valid = 1'b1;
      in_data  = bp_data[0];
      in_mode  = bp_mode[0];
      cur_exp  = bp_exp[0];
      repeat (6) begin
         @(negedge clk);
         if (in_ready) acc++;
         @(posedge clk);
         #1;
         if (acc < 5) begin
            in_data = bp_data[acc];
            in_mode = bp_mode[acc];
            cur_exp = bp_exp[acc];
         end
      end
      chkn("bp_accepted", acc, 2);
      chk1("bp_in_ready", in_ready, 1'b0);
      out_ready = 1'b1;
      for (int i = 2; i < 5; i++) send(bp_data[i], bp_mode[i], bp_exp[i]);
      idle(5);
      chkn("bp_results", n_out - n0, 5);
      chkn("bp_queue_empty", exp_q.size(), 0);
      chkn("hit_cnt_6", int'(hit_cnt), 6);

      // Saturation, then clr alone, then clr together with a hit
      for (int i = 0; i < 300; i++) send(16'h0000, 2'b00, 1'b1);
      idle(4);
      chkn("hit_cnt_sat", int'(hit_cnt), 255);
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      chkn("clr_alone_cnt", int'(hit_cnt), 0);
      chk1("clr_alone_sticky", sticky, 1'b0);
      send(16'h0000, 2'b00, 1'b1);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      chkn("clr_hit_cnt", int'(hit_cnt), 1);
      chk1("clr_hit_sticky", sticky, STK);
      idle(3);

      // Reset with two entries in flight
      out_ready = 1'b0;
      send(16'h0000, 2'b00, 1'b1);
      send(16'hFFFF, 2'b01, 1'b1);
      in_valid = 1'b0;
      chk1("inflight_valid", out_valid, 1'b1);
      n0 = n_out;
      #2 rst_n = 1'b0;
      #1;
      chk1("midrst_out_valid", out_valid, 1'b0);
      chk1("midrst_out_flag", out_flag, 1'b0);
      chkn("midrst_hit_cnt", int'(hit_cnt), 0);
      chk1("midrst_sticky", sticky, 1'b0);
      out_ready = 1'b1;
      @(negedge clk);
      #2 rst_n = 1'b1;
      #1;
      chk1("midrst_in_ready", in_ready, 1'b1);
      idle(10);
      chkn("midrst_no_out", n_out - n0, 0);
      chkn("midrst_hit_after", int'(hit_cnt), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
